// File: rtl/io_handshake_ctrl.sv
// io_handshake_ctrl
//   Stalls the PC on decoded IN/OUT instructions until the user presses the
//   insert button, then acknowledges with an insert pulse train.
//   IN  : captures the switch bank into in_data with a one-cycle in_valid strobe.
//   OUT : latches out_data onto display when the request is accepted.
//   Optional feature macro: IO_DEBOUNCE_EN adds a stable-level button filter.
// Ports
//   CLK, reset          clock, synchronous active-high reset
//   io_in_req/io_out_req decoder requests (IN has priority)
//   out_data            register value for OUT
//   switches            async switch bank, zero-extended into in_data
//   insert_btn          async raw push button
//   input_flag/output_flag  combinational PC stall flags
//   insert              registered acknowledge, INSERT_HOLD cycles high
//   in_data/in_valid    captured switches and write strobe
//   display             held OUT value
module io_handshake_ctrl #(
  parameter int DATA_W       = 16,
  parameter int INSERT_HOLD  = 6,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              io_in_req,
  input  logic              io_out_req,
  input  logic [31:0]       out_data,
  input  logic [DATA_W-1:0] switches,
  input  logic              insert_btn,
  output logic              input_flag,
  output logic              output_flag,
  output logic              insert,
  output logic [31:0]       in_data,
  output logic              in_valid,
  output logic [31:0]       display
);

  localparam int CW = (INSERT_HOLD > 1) ? $clog2(INSERT_HOLD) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_IN, WAIT_OUT, ACK} state_t;

  state_t            state;
  logic              kind_in;   // 1: op in ACK is IN, 0: OUT
  logic [CW-1:0]     hold_cnt;

  // two-flop synchronisers for the button and the switch bank
  logic              btn_s1, btn_s2;
  logic [DATA_W-1:0] sw_s1, sw_s2;

  always_ff @(posedge CLK) begin
    if (reset) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      btn_s1 <= insert_btn;
      btn_s2 <= btn_s1;
      sw_s1  <= switches;
      sw_s2  <= sw_s1;
    end
  end

  logic btn_lvl;   // level seen by the edge detector
  logic btn_prev;
  logic press;

`ifdef IO_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  logic          btn_filt;
  logic [DW-1:0] db_cnt;

  // filtered level follows btn_s2 only after DEBOUNCE_CYC consecutive
  // cycles of disagreement; any agreement restarts the count
  always_ff @(posedge CLK) begin
    if (reset) begin
      btn_filt <= 1'b0;
      db_cnt   <= '0;
    end else if (btn_s2 != btn_filt) begin
      if (db_cnt == DW'(DEBOUNCE_CYC - 1)) begin
        btn_filt <= btn_s2;
        db_cnt   <= '0;
      end else begin
        db_cnt   <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  assign btn_lvl = btn_filt;
`else
  assign btn_lvl = btn_s2;
`endif

  always_ff @(posedge CLK) begin
    if (reset) btn_prev <= 1'b0;
    else       btn_prev <= btn_lvl;
  end

  // a button already high when WAIT_* is entered produces no edge
  assign press = btn_lvl & ~btn_prev;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state    <= IDLE;
      kind_in  <= 1'b0;
      hold_cnt <= '0;
      insert   <= 1'b0;
      in_valid <= 1'b0;
      in_data  <= '0;
      display  <= '0;
    end else begin
      in_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (io_in_req) begin
            state   <= WAIT_IN;
            kind_in <= 1'b1;
          end else if (io_out_req) begin
            state   <= WAIT_OUT;
            kind_in <= 1'b0;
            display <= out_data;
          end
        end
        WAIT_IN: begin
          if (press) begin
            in_data  <= 32'(sw_s2);
            in_valid <= 1'b1;
            insert   <= 1'b1;
            hold_cnt <= '0;
            state    <= ACK;
          end
        end
        WAIT_OUT: begin
          if (press) begin
            insert   <= 1'b1;
            hold_cnt <= '0;
            state    <= ACK;
          end
        end
        ACK: begin
          if (hold_cnt == CW'(INSERT_HOLD - 1)) begin
            insert   <= 1'b0;
            hold_cnt <= '0;
            state    <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // combinational so the PC stalls in the request cycle itself
  assign input_flag  = (state == IDLE && io_in_req) || (state == WAIT_IN) ||
                       (state == ACK && kind_in);
  assign output_flag = (state == IDLE && io_out_req && !io_in_req) ||
                       (state == WAIT_OUT) || (state == ACK && !kind_in);

endmodule

// File: tb/tb_io_handshake_ctrl.sv
module tb_io_handshake_ctrl;

  localparam int DEB = 4;
`ifdef IO_DEBOUNCE_EN
  localparam int PRESS_LAT = 2 + DEB + 1;
`else
  localparam int PRESS_LAT = 3;
`endif

  logic        CLK = 1'b0;
  logic        reset, io_in_req, io_out_req, insert_btn;
  logic [31:0] out_data;
  logic [15:0] switches;
  logic        input_flag, output_flag, insert, in_valid;
  logic [31:0] in_data, display;

  int checks = 0;
  int failures = 0;

  io_handshake_ctrl #(.DATA_W(16), .INSERT_HOLD(6), .DEBOUNCE_CYC(DEB)) dut (
    .CLK(CLK), .reset(reset), .io_in_req(io_in_req), .io_out_req(io_out_req),
    .out_data(out_data), .switches(switches), .insert_btn(insert_btn),
    .input_flag(input_flag), .output_flag(output_flag), .insert(insert),
    .in_data(in_data), .in_valid(in_valid), .display(display)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst, inr, outr;
    logic [31:0] od;
    logic        ifl, ofl, ins, iv;
    logic [31:0] idat, disp;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // step to the next cycle: inputs change right after negedge, sample 1ns later
  task automatic step();
    @(negedge CLK);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // request must already be accepted and the button filtered low
  task automatic press_ack(input string nm, input bit is_in, input logic [31:0] exp_d);
    int n, ic, vc;
    bit got;
    step(); insert_btn = 1'b1;
    n = 0; got = 0;
    while (n < 40 && !got) begin
      step(); #1; n++;
      if (insert) got = 1;
      else chk({nm, " stall flag"}, is_in ? input_flag : output_flag, 1);
    end
    chk({nm, " press latency"}, n, PRESS_LAT);
    ic = 0; vc = 0;
    if (got) begin
      chk({nm, " in_valid first"}, in_valid, is_in);
      if (is_in) chk({nm, " in_data"}, in_data, exp_d);
      while (insert && ic < 20) begin
        ic++;
        if (in_valid) vc++;
        chk({nm, " flag in ack"}, is_in ? input_flag : output_flag, 1);
        step(); #1;
      end
    end
    chk({nm, " insert cycles"}, ic, 6);
    chk({nm, " in_valid pulses"}, vc, is_in);
    chk({nm, " flag cleared"}, is_in ? input_flag : output_flag, 0);
    if (!is_in) chk({nm, " display held"}, display, exp_d);
    insert_btn = 1'b0;
  endtask

  vec_t tbl[11];

  initial begin
    vec_t v;
    int vc;
    //       rst  inr  outr od             ifl  ofl  ins  iv   idat   disp
    tbl[0]  = '{0, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0, 32'h0};
    tbl[1]  = '{0, 0, 1, 32'h12345678,   0, 1, 0, 0, 32'h0, 32'h0};
    tbl[2]  = '{0, 0, 0, 32'h0,          0, 1, 0, 0, 32'h0, 32'h12345678};
    tbl[3]  = '{0, 1, 0, 32'h0,          0, 1, 0, 0, 32'h0, 32'h12345678};
    tbl[4]  = '{1, 0, 0, 32'h0,          0, 1, 0, 0, 32'h0, 32'h12345678};
    tbl[5]  = '{0, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0, 32'h0};
    tbl[6]  = '{0, 1, 1, 32'hAAAA5555,   1, 0, 0, 0, 32'h0, 32'h0};
    tbl[7]  = '{0, 0, 0, 32'h0,          1, 0, 0, 0, 32'h0, 32'h0};
    tbl[8]  = '{0, 0, 1, 32'hCAFEF00D,   1, 0, 0, 0, 32'h0, 32'h0};
    tbl[9]  = '{1, 0, 0, 32'h0,          1, 0, 0, 0, 32'h0, 32'h0};
    tbl[10] = '{0, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0, 32'h0};

    reset = 1'b1; io_in_req = 1'b0; io_out_req = 1'b0; insert_btn = 1'b0;
    out_data = '0; switches = 16'hBEEF;
    @(posedge CLK); @(posedge CLK);

    // request/flag/display behaviour without presses, including reset and priority
    for (int i = 0; i < 11; i++) begin
      v = tbl[i];
      step();
      reset = v.rst; io_in_req = v.inr; io_out_req = v.outr; out_data = v.od;
      #1;
      chk($sformatf("vec[%0d]", i),
          {20'h0, input_flag, output_flag, insert, in_valid, 8'h0},
          {20'h0, v.ifl, v.ofl, v.ins, v.iv, 8'h0});
      chk($sformatf("vec[%0d] in_data", i), in_data, v.idat);
      chk($sformatf("vec[%0d] display", i), display, v.disp);
    end
    step(); reset = 1'b0; io_in_req = 1'b0; io_out_req = 1'b0;
    idle_cycles(DEB + 4);

    // IN with BEEF
    step(); io_in_req = 1'b1; #1;
    chk("in req cycle flag", input_flag, 1);
    step(); io_in_req = 1'b0;
    press_ack("in_beef", 1'b1, 32'h0000BEEF);

    // OUT back-to-back right after the IN ack exits
    step(); io_out_req = 1'b1; out_data = 32'h12345678; #1;
    chk("out req cycle flag", output_flag, 1);
    chk("out input_flag low", input_flag, 0);
    step(); io_out_req = 1'b0; out_data = 32'hFFFFFFFF; #1;
    chk("out display latched", display, 32'h12345678);
    idle_cycles(DEB + 4);
    press_ack("out_1234", 1'b0, 32'h12345678);
    chk("in_data held after out", in_data, 32'h0000BEEF);
    idle_cycles(DEB + 4);

    // button held before IN request: no ack until a fresh press
    switches = 16'h8001;
    step(); insert_btn = 1'b1;
    idle_cycles(DEB + 8);
    step(); io_in_req = 1'b1;
    step(); io_in_req = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(); #1;
      chk("held btn stall", {input_flag, insert}, 2'b10);
    end
    insert_btn = 1'b0;
    idle_cycles(DEB + 4);
    press_ack("in_repress", 1'b1, 32'h00008001);
    chk("display held after in", display, 32'h12345678);
    idle_cycles(DEB + 4);

    // reset during ACK aborts everything
    step(); io_in_req = 1'b1;
    step(); io_in_req = 1'b0; insert_btn = 1'b1;
    vc = 0;
    while (vc < 40 && !insert) begin step(); #1; vc++; end
    chk("reset test reached ack", insert, 1);
    step(); step(); reset = 1'b1;
    step(); step(); #1;
    chk("reset outs", {input_flag, output_flag, insert, in_valid}, 4'b0000);
    chk("reset in_data", in_data, 0);
    chk("reset display", display, 0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(); #1;
      chk("post reset idle", {input_flag, output_flag, insert, in_valid}, 4'b0000);
    end
    insert_btn = 1'b0;
    idle_cycles(DEB + 4);

    // bouncing button: exactly one capture
    switches = 16'h1234;
    step(); io_in_req = 1'b1;
    step(); io_in_req = 1'b0;
    vc = 0;
    for (int i = 0; i < 10; i++) begin
      step(); insert_btn = ~insert_btn; #1;
      if (in_valid) vc++;
    end
    insert_btn = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step(); #1;
      if (in_valid) vc++;
    end
    chk("bounce in_valid count", vc, 1);
    chk("bounce in_data", in_data, 32'h00001234);
    chk("bounce back to idle", {input_flag, insert}, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end

endmodule
